// File: rtl/mdu_iter.sv
// mdu_iter: multiply/divide unit for the EX stage, holding the HI/LO registers.
// Multiply-class ops take a fixed MUL_LAT cycles. Divide is an iterative
// restoring divider that produces one quotient bit per cycle, W cycles in all.
// Optional build macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 6-9).
// Without it those opcodes are ignored and no accumulate adder is built.
// Handshake: start is sampled only while busy is low and cancel is low.
// busy stays high from the edge after issue until the commit edge, and
// done pulses for one cycle after that commit edge.
module mdu_iter #(
  parameter int W       = 32,
  parameter int MUL_LAT = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  localparam int CMAX = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     op_q, op_d;
  // x: multiplicand, or dividend/quotient shift register during divide
  logic [W-1:0]   x_q, x_d;
  // y: multiplier, or divisor magnitude during divide
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic           done_q, done_d;

  // Multiply datapath: 2W-bit product of sign- or zero-extended operands
  logic           mul_signed;
  logic [2*W-1:0] mx, my, prod, mul_res;

  // Divide datapath: one restoring step
  logic [W:0]     rem_sh, diff;
  logic           q_bit;
  logic [W-1:0]   rem_n, quo_n, quo_fix, rem_fix;

  // Issue-time operand handling for divide
  logic           div_signed;
  logic [W-1:0]   a_mag, b_mag;

  // Multiply product and optional accumulation against the current HI/LO
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    mx   = mul_signed ? {{W{x_q[W-1]}}, x_q} : {{W{1'b0}}, x_q};
    my   = mul_signed ? {{W{y_q[W-1]}}, y_q} : {{W{1'b0}}, y_q};
    prod = mx * my;
`ifdef MDU_MADD_EN
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:           mul_res = prod;
    endcase
`else
    mul_res = prod;
`endif
  end

  // One restoring divide step plus final sign correction
  always_comb begin
    rem_sh  = {rem_q, x_q[W-1]};
    diff    = rem_sh - {1'b0, y_q};
    q_bit   = ~diff[W];
    rem_n   = q_bit ? diff[W-1:0] : rem_sh[W-1:0];
    quo_n   = {x_q[W-2:0], q_bit};
    quo_fix = qneg_q ? ({W{1'b0}} - quo_n) : quo_n;
    rem_fix = rneg_q ? ({W{1'b0}} - rem_n) : rem_n;
  end

  // Operand magnitudes for a signed divide issue
  always_comb begin
    div_signed = (op == OP_DIV);
    a_mag = (div_signed && a[W-1]) ? ({W{1'b0}} - a) : a;
    b_mag = (div_signed && b[W-1]) ? ({W{1'b0}} - b) : b;
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`else
            OP_MULT, OP_MULTU: begin
`endif
              op_d    = op;
              x_d     = a;
              y_d     = b;
              cnt_d   = CW'(MUL_LAT);
              state_d = MUL;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              x_d     = a_mag;
              y_d     = b_mag;
              rem_d   = '0;
              qneg_d  = div_signed && (a[W-1] ^ b[W-1]);
              rneg_d  = div_signed && a[W-1];
              bz_d    = (b == '0);
              cnt_d   = CW'(W);
              state_d = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_d    = mul_res[2*W-1:W];
            lo_d    = mul_res[W-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DIV: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          rem_d = rem_n;
          x_d   = quo_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (!bz_q) begin
              lo_d = quo_fix;
              hi_d = rem_fix;
            end
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter (W=32, MUL_LAT=5). Reads MDU_MADD_EN the same way
// as the design so the accumulate expectations follow the build.
module tb_mdu_iter;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cancel = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int done_seen = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;

  mdu_iter #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [2*W-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic [W-1:0] h,
                                           input logic [W-1:0] l);
    logic [2*W-1:0] hl, ps, pu;
    longint sx, sy, q, r;
    hl = {h, l};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ps = sx * sy;
    pu = {32'b0, x} * {32'b0, y};
    case (o)
      4'd0: return ps;
      4'd1: return pu;
      4'd2: begin
        if (y == '0) return hl;
        q = sx / sy;
        r = sx % sy;
        return {r[W-1:0], q[W-1:0]};
      end
      4'd3: begin
        if (y == '0) return hl;
        return {x % y, x / y};
      end
      4'd4: return {x, l};
      4'd5: return {h, x};
`ifdef MDU_MADD_EN
      4'd6: return hl + ps;
      4'd7: return hl + pu;
      4'd8: return hl - ps;
      4'd9: return hl - pu;
`endif
      default: return hl;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] o);
    case (o)
      4'd0, 4'd1: return MUL_LAT;
      4'd2, 4'd3: return W;
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: return MUL_LAT;
`endif
      default: return 0;
    endcase
  endfunction

  // driver tasks
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1 start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Push expectation, issue, then check busy length and HI/LO
  task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    logic [2*W-1:0] e;
    int n;
    int lat;
    lat = lat_of(o);
    e = model(o, x, y, m_hi, m_lo);
    if (lat > 0) begin
      exp_q.push_back(e);
      pushed++;
    end
    {m_hi, m_lo} = e;
    issue(o, x, y);
    wait_idle(n);
    check({tag, "_busy_len"}, 64'(n), 64'(lat));
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  // scoreboard: every done pulse pops one expected HI/LO value
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'(0));
      else check("done_hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  initial begin : main
    int n;
    logic [3:0] ops[4];
    logic [3:0] ro;
    logic [W-1:0] ra, rb;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3};

    do_reset();
    @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));

    do_op("mult_m2x3", 4'd0, 32'hFFFFFFFE, 32'd3);
    check("mult_m2x3_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    do_op("div_m7_2", 4'd2, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    do_op("divu_7_2", 4'd3, 32'd7, 32'd2);
    check("divu_7_2_const", {hi, lo}, {32'd1, 32'd3});

    do_op("div_ovf", 4'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);

    do_op("mthi_11", 4'd4, 32'h11, 32'h0);
    do_op("mtlo_22", 4'd5, 32'h22, 32'h0);
    do_op("divu_by0", 4'd3, 32'd55, 32'd0);
    check("divu_by0_const", {hi, lo}, {32'h11, 32'h22});

    do_op("mthi_1234", 4'd4, 32'h1234, 32'h0);
    check("mthi_1234_const", 64'(hi), 64'h1234);

    do_op("nop_12", 4'd12, 32'hAAAA, 32'h5555);

    // MTLO while a DIV is in flight must be dropped
    exp_q.push_back(model(4'd2, 32'hFFFFFF9C, 32'd7, m_hi, m_lo));
    pushed++;
    {m_hi, m_lo} = model(4'd2, 32'hFFFFFF9C, 32'd7, m_hi, m_lo);
    issue(4'd2, 32'hFFFFFF9C, 32'd7);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = 4'd5; a = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(n);
    check("mtlo_busy_hilo", {hi, lo}, {m_hi, m_lo});

    // cancel in busy cycle 10 of a DIVU
    issue(4'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    check("cancel_hilo", {hi, lo}, {m_hi, m_lo});

    // cancel together with start: start ignored
    @(posedge clk);
    #1 start = 1'b1; cancel = 1'b1; op = 4'd0; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("start_cancel_busy", 64'(busy), 64'(0));

    // MADDU wrap across LO into HI
    do_op("mthi_0", 4'd4, 32'h0, 32'h0);
    do_op("mtlo_ff", 4'd5, 32'hFFFFFFFF, 32'h0);
    do_op("maddu_1x1", 4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("maddu_const", {hi, lo}, 64'h00000001_00000000);
    do_op("msub", 4'd8, 32'hFFFFFFFD, 32'd4);
`else
    check("maddu_const", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    // randomized mult/div traffic, with some zero/extreme divisors
    for (int i = 0; i < 16; i++) begin
      ro = ops[$urandom_range(0, 3)];
      ra = $urandom();
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 15);
        default: rb = $urandom();
      endcase
      do_op("rand", ro, ra, rb);
    end

    // reset in the middle of a MULT: nothing commits
    do_op("mthi_pre", 4'd4, 32'h77, 32'h0);
    issue(4'd0, 32'd5, 32'd6);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    repeat (8) @(negedge clk);
    check("rst_mid_hilo_late", {hi, lo}, 64'h0);

    check("done_count", 64'(done_seen), 64'(pushed));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core.
- Holds the HI/LO architectural registers.
- Multiply: fixed configurable latency. Divide: true iterative restoring divider, one quotient bit per cycle.
- Adds cancel support for exception flush; optional multiply-accumulate ops.
- Pipeline stalls any HI/LO-reading or MDU-issuing instruction while busy is high.

Parameters:
- W, 32: operand and HI/LO width (≥4, even).
- MUL_LAT, 5: cycles busy is high for multiply-class ops (≥1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- start  input  1  issue op this cycle
- op  input  4  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU, 10-15 no-op
- a  input  W  rs operand
- b  input  W  rt operand
- cancel  input  1  abort in-flight op (exception/flush)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse on the edge where HI/LO commit a mult/div result
- hi  output  W  HI register
- lo  output  W  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset overrides everything, including mid-operation; no partial result is committed.
- States: IDLE, MUL, DIV.
- IDLE + start + !cancel:
  - op 4/5: hi or lo <= a at the next edge. busy stays 0, no done.
  - op 0/1/6-9: latch operands, load counter with MUL_LAT, go to MUL, busy=1 from the next cycle.
  - op 2/3: latch |a|,|b| (signed) or a,b (unsigned) and the sign flags, load counter with W, go to DIV, busy=1.
  - op 10-15: ignored.
- start while busy: ignored entirely, including MTHI/MTLO.
- MUL: counter decrements each cycle. On the edge where counter reaches 1, commit and return to IDLE.
  - MULT: {hi,lo} = signed a × signed b, 2W bits.
  - MULTU: unsigned product.
  - MADD/MADDU: {hi,lo} += product. MSUB/MSUBU: {hi,lo} −= product.
  - Accumulate is 2W-bit modulo wrap and uses hi/lo as they were at issue time.
- DIV: one restoring step per cycle: shift remainder, trial subtract, set quotient bit. After W steps, commit and return to IDLE.
  - Commit: lo = quotient, hi = remainder.
  - Signed: quotient truncated toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1: lo = most-negative, hi = 0.
  - b == 0: hi/lo unchanged, but busy still runs the full W cycles and done still pulses.
- Busy timing: start at edge T → busy high from T+1 for exactly MUL_LAT (mult) or W (div) cycles. Commit, done=1 and busy=0 all take effect at the same edge.
- hi/lo are unchanged while busy.
- cancel with busy=1: next edge returns to IDLE, busy=0, no commit, no done; hi/lo keep pre-op values.
- cancel in the same cycle as start: start ignored. cancel while IDLE: no effect.
- Internal arithmetic is 2W-bit. No $signed division operators; the divider is the explicit iterative datapath.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 6-9 behave as above.
- Undefined: ops 6-9 are treated as no-op (ignored like 10-15, busy stays 0) and the accumulate adder is not synthesised.

Test Plan:
- MULT a=0xFFFFFFFE (−2), b=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy 32 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU b=0 with hi=0x11, lo=0x22 preset → after 32 cycles hi=0x11, lo=0x22, done=1.
- MTHI a=0x1234 while idle → hi=0x1234 next edge, busy stays 0. MTLO issued while busy from a DIV → ignored, lo takes the DIV result only.
- DIVU 100/7 started, cancel asserted in busy cycle 10 → busy=0 next cycle, hi/lo keep prior values, no done. Reset mid-MULT → hi=lo=0, busy=0.
- With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0. Without the macro, same stimulus → busy never asserts, hi/lo unchanged.
